outport_link_sequencer: RTL and testbench

//  Credit-aware output-port sequencer: grants one of four input-port requests round-robin,

---
 rtl/outport_link_sequencer.sv | 128 ++++++++++++
 tb/tb_outport_link_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/outport_link_sequencer.sv
// Output-port sequencer for one router port: round-robin grant over four input ports,
// holds the crossbar select for one packet, and strobes flits while downstream credits remain.
`ifndef X_POS
`define X_POS 2'd0
`endif

module outport_link_sequencer #(
   parameter logic [1:0] PORT_DIR         = `X_POS,
   parameter int         CREDITS          = 5,
   parameter int         FLITS_PER_PACKET = 5,
   parameter int         CNT_W            = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       port_request_din,
   input  logic             credit_in_din,
   output logic [3:0]       xbar_conf_vector_dout,
   output logic [3:0]       transfer_strobe_vector_dout,
   output logic             port_status_dout,
   output logic [CNT_W-1:0] credit_count_dout,
   output logic             credit_error_dout
);

   // PORT_DIR only labels the instance; the zero term keeps it referenced without effect.
   localparam int               LAST_FLIT_I = FLITS_PER_PACKET - 1 + 0 * int'(PORT_DIR);
   localparam logic [CNT_W-1:0] LAST_FLIT   = CNT_W'(LAST_FLIT_I);
   localparam logic [CNT_W-1:0] MAX_CREDIT  = CNT_W'(CREDITS);
   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

   typedef enum logic {
      IDLE     = 1'b0,
      TRANSFER = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       xbar, xbar_nxt;
   logic [1:0]       rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0] flit_cnt, flit_cnt_nxt;
   logic [CNT_W-1:0] credit_cnt, credit_cnt_nxt;
   logic             credit_err, credit_err_nxt;
   logic             strobe_en;
   logic             grant_valid;
   logic [1:0]       grant_idx;

   // Walk from the highest offset down so the candidate closest to rr_ptr wins.
   always_comb begin
      logic [1:0] cand;
      grant_valid = 1'b0;
      grant_idx   = rr_ptr;
      cand        = rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         cand = rr_ptr + 2'(k);
         if (port_request_din[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign strobe_en = (state == TRANSFER) && (credit_cnt != '0);

   always_comb begin
      state_nxt    = state;
      xbar_nxt     = xbar;
      rr_ptr_nxt   = rr_ptr;
      flit_cnt_nxt = flit_cnt;
      unique case (state)
         IDLE: begin
            if (grant_valid) begin
               xbar_nxt   = 4'b0001 << grant_idx;
               rr_ptr_nxt = grant_idx + 2'd1;
               state_nxt  = TRANSFER;
            end
         end
         TRANSFER: begin
            // Requests are ignored here; only credits pace the packet.
            if (strobe_en) begin
               if (flit_cnt == LAST_FLIT) begin
                  flit_cnt_nxt = '0;
                  xbar_nxt     = 4'b0000;
                  state_nxt    = IDLE;
               end else begin
                  flit_cnt_nxt = flit_cnt + ONE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      credit_cnt_nxt = credit_cnt;
      credit_err_nxt = credit_err;
      unique case ({credit_in_din, strobe_en})
         2'b10: begin
            if (credit_cnt == MAX_CREDIT) credit_err_nxt = 1'b1;
            else                          credit_cnt_nxt = credit_cnt + ONE;
         end
         2'b01:   credit_cnt_nxt = credit_cnt - ONE;
         default: credit_cnt_nxt = credit_cnt;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         xbar       <= 4'b0000;
         rr_ptr     <= 2'd0;
         flit_cnt   <= '0;
         credit_cnt <= MAX_CREDIT;
         credit_err <= 1'b0;
      end else begin
         state      <= state_nxt;
         xbar       <= xbar_nxt;
         rr_ptr     <= rr_ptr_nxt;
         flit_cnt   <= flit_cnt_nxt;
         credit_cnt <= credit_cnt_nxt;
         credit_err <= credit_err_nxt;
      end
   end

   assign xbar_conf_vector_dout       = xbar;
   assign transfer_strobe_vector_dout = xbar & {4{strobe_en}};
   assign port_status_dout            = (state == IDLE) && (credit_cnt != '0);
   assign credit_count_dout           = credit_cnt;
   assign credit_error_dout           = credit_err;

endmodule

// File: tb/tb_outport_link_sequencer.sv
// Bench for outport_link_sequencer: directed packets, expected strobes queued at issue time
// and consumed by a negedge monitor; register-level checks done inline.
module tb_outport_link_sequencer;

   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       port_request_din;
   logic             credit_in_din;
   logic [3:0]       xbar_conf_vector_dout;
   logic [3:0]       transfer_strobe_vector_dout;
   logic             port_status_dout;
   logic [CNT_W-1:0] credit_count_dout;
   logic             credit_error_dout;

   logic [3:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   outport_link_sequencer #(
      .CREDITS          (5),
      .FLITS_PER_PACKET (5),
      .CNT_W            (CNT_W)
   ) dut (
      .clk                         (clk),
      .reset                       (reset),
      .port_request_din            (port_request_din),
      .credit_in_din               (credit_in_din),
      .xbar_conf_vector_dout       (xbar_conf_vector_dout),
      .transfer_strobe_vector_dout (transfer_strobe_vector_dout),
      .port_status_dout            (port_status_dout),
      .credit_count_dout           (credit_count_dout),
      .credit_error_dout           (credit_error_dout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [3:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      port_request_din = 4'b0000;
      credit_in_din    = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   // Monitor: every strobe the DUT presents must match the oldest queued expectation.
   always @(negedge clk) begin
      logic [3:0] e;
      if (!reset && transfer_strobe_vector_dout != 4'b0000) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got %b expected none", transfer_strobe_vector_dout);
         end else begin
            e = exp_q.pop_front();
            check("strobe", int'(transfer_strobe_vector_dout), int'(e));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b1;
      port_request_din = 4'b0000;
      credit_in_din    = 1'b0;
      tick(2);
      reset = 1'b0;
      check("rst_xbar",   int'(xbar_conf_vector_dout), 0);
      check("rst_strobe", int'(transfer_strobe_vector_dout), 0);
      check("rst_status", int'(port_status_dout), 1);
      check("rst_credit", int'(credit_count_dout), 5);
      check("rst_error",  int'(credit_error_dout), 0);

      // T1: single packet from port 2, credits drain 5 -> 0
      push(4'b0100, 5);
      port_request_din = 4'b0100;
      tick(1);
      check("t1_xbar_grant", int'(xbar_conf_vector_dout), 4);
      port_request_din = 4'b0000;
      tick(5);
      check("t1_xbar_release", int'(xbar_conf_vector_dout), 0);
      check("t1_credit_zero",  int'(credit_count_dout), 0);
      check("t1_status_busy",  int'(port_status_dout), 0);

      // T4: refill, then one credit too many while idle
      credit_in_din = 1'b1;
      tick(5);
      credit_in_din = 1'b0;
      check("t4_refill",   int'(credit_count_dout), 5);
      check("t4_no_error", int'(credit_error_dout), 0);
      credit_in_din = 1'b1;
      tick(1);
      credit_in_din = 1'b0;
      check("t4_overflow_count", int'(credit_count_dout), 5);
      check("t4_overflow_error", int'(credit_error_dout), 1);
      tick(2);
      check("t4_error_sticky", int'(credit_error_dout), 1);
      do_reset();
      check("t4_error_cleared", int'(credit_error_dout), 0);

      // T2: all ports requesting, credit returned every cycle
      push(4'b0001, 5);
      push(4'b0010, 5);
      push(4'b0100, 5);
      push(4'b1000, 5);
      push(4'b0001, 5);
      port_request_din = 4'b1111;
      credit_in_din    = 1'b1;
      tick(6);
      check("t2_bubble_xbar",   int'(xbar_conf_vector_dout), 0);
      check("t2_bubble_status", int'(port_status_dout), 1);
      check("t2_credit_steady", int'(credit_count_dout), 5);
      tick(1);
      check("t2_second_grant", int'(xbar_conf_vector_dout), 2);
      tick(23);
      port_request_din = 4'b0000;
      credit_in_din    = 1'b0;
      check("t2_credit_end", int'(credit_count_dout), 5);
      check("t2_queue_empty", exp_q.size(), 0);
      do_reset();

      // T3: no credit returns; second packet granted but stalls
      push(4'b0001, 5);
      port_request_din = 4'b0011;
      tick(6);
      check("t3_credit_zero", int'(credit_count_dout), 0);
      check("t3_status_busy", int'(port_status_dout), 0);
      tick(1);
      check("t3_second_grant", int'(xbar_conf_vector_dout), 2);
      check("t3_stalled",      int'(transfer_strobe_vector_dout), 0);
      port_request_din = 4'b0000;
      tick(2);
      check("t3_xbar_held", int'(xbar_conf_vector_dout), 2);
      push(4'b0010, 2);
      credit_in_din = 1'b1;
      tick(2);
      check("t3_credit_and_strobe", int'(credit_count_dout), 1);
      credit_in_din = 1'b0;
      tick(3);
      check("t3_stall_xbar",   int'(xbar_conf_vector_dout), 2);
      check("t3_stall_credit", int'(credit_count_dout), 0);
      check("t3_two_strobes",  exp_q.size(), 0);
      push(4'b0010, 3);
      credit_in_din = 1'b1;
      tick(3);
      credit_in_din = 1'b0;
      tick(1);
      check("t3_finish_xbar",   int'(xbar_conf_vector_dout), 0);
      check("t3_finish_credit", int'(credit_count_dout), 0);
      do_reset();

      // T5: requester drops after strobe 2, packet still completes
      push(4'b1000, 5);
      port_request_din = 4'b1000;
      tick(2);
      port_request_din = 4'b0000;
      tick(1);
      check("t5_xbar_held", int'(xbar_conf_vector_dout), 8);
      tick(3);
      check("t5_release", int'(xbar_conf_vector_dout), 0);
      check("t5_credit",  int'(credit_count_dout), 0);
      do_reset();

      // T6: asynchronous reset after strobe 3
      push(4'b0100, 3);
      port_request_din = 4'b0100;
      tick(1);
      port_request_din = 4'b0000;
      tick(2);
      #2 reset = 1'b1;
      #1;
      check("t6_async_xbar",   int'(xbar_conf_vector_dout), 0);
      check("t6_async_strobe", int'(transfer_strobe_vector_dout), 0);
      check("t6_async_credit", int'(credit_count_dout), 5);
      tick(1);
      push(4'b0001, 5);
      port_request_din = 4'b1111;
      reset = 1'b0;
      check("t6_status", int'(port_status_dout), 1);
      tick(1);
      check("t6_rr_reset", int'(xbar_conf_vector_dout), 1);
      port_request_din = 4'b0000;
      tick(5);
      check("t6_release", int'(xbar_conf_vector_dout), 0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
